// File: rtl/fpga_cfg_sequencer.sv
// Backend configuration master: sequences o_resetbAll, waits for ready, then shifts frames out on o_sclk/o_sdout.
// Optional macro CFG_PARITY_EN appends an even-parity bit after the LSB of every frame.
module fpga_cfg_sequencer #(
  parameter int FRAME_W       = 8,
  parameter int SCLK_HALF     = 4,
  parameter int RST_HOLD      = 16,
  parameter int READY_TIMEOUT = 1024,
  parameter int GAP_CYC       = 8
) (
  input  logic               i_mainclk,
  input  logic               i_resetbFPGA,
  input  logic               i_ready,
  input  logic [FRAME_W-1:0] i_cfg_data,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  output logic               o_resetbAll,
  output logic               o_sclk,
  output logic               o_sdout,
  output logic               o_busy,
  output logic               o_timeout
);

`ifdef CFG_PARITY_EN
  localparam int NBITS = FRAME_W + 1;

  function automatic logic even_parity(input logic [FRAME_W-1:0] d);
    return ^d;
  endfunction
`else
  localparam int NBITS = FRAME_W;
`endif

  localparam int CNT_MAX = (RST_HOLD > READY_TIMEOUT) ?
                           ((RST_HOLD > GAP_CYC) ? RST_HOLD : GAP_CYC) :
                           ((READY_TIMEOUT > GAP_CYC) ? READY_TIMEOUT : GAP_CYC);
  localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BIT_W  = $clog2(NBITS);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_IDLE       = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [HALF_W-1:0]  half_cnt_r, half_cnt_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_s;
  // Bits still to send after the one currently on o_sdout, next bit at the top.
  logic [NBITS-2:0]   rem_r, rem_s;
  logic               ready_meta_r, ready_sync_r;
  logic               resetb_all_r, resetb_all_s;
  logic               cfg_ready_r, cfg_ready_s;
  logic               sclk_r, sclk_s;
  logic               sdout_r, sdout_s;
  logic               busy_r, busy_s;
  logic               timeout_r, timeout_s;

  // Next-state and next-output decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    half_cnt_s   = half_cnt_r;
    bit_cnt_s    = bit_cnt_r;
    rem_s        = rem_r;
    resetb_all_s = resetb_all_r;
    cfg_ready_s  = cfg_ready_r;
    sclk_s       = sclk_r;
    sdout_s      = sdout_r;
    busy_s       = busy_r;
    timeout_s    = timeout_r;

    case (state_r)
      ST_RESET_HOLD: begin
        resetb_all_s = 1'b0;
        cfg_ready_s  = 1'b0;
        sclk_s       = 1'b0;
        sdout_s      = 1'b0;
        busy_s       = 1'b0;
        if (cnt_r == CNT_W'(RST_HOLD - 1)) begin
          resetb_all_s = 1'b1;
          cnt_s        = '0;
          state_s      = ST_WAIT_READY;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_READY: begin
        if (ready_sync_r) begin
          cfg_ready_s = 1'b1;
          cnt_s       = '0;
          state_s     = ST_IDLE;
        end else if (cnt_r == CNT_W'(READY_TIMEOUT - 1)) begin
          timeout_s    = 1'b1;
          resetb_all_s = 1'b0;
          cnt_s        = '0;
          state_s      = ST_RESET_HOLD;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_IDLE, ST_SHIFT, ST_GAP: begin
        if (!ready_sync_r) begin
          // Backend lost ready: drop the word in flight and go back to waiting.
          cfg_ready_s = 1'b0;
          sclk_s      = 1'b0;
          sdout_s     = 1'b0;
          busy_s      = 1'b0;
          cnt_s       = '0;
          half_cnt_s  = '0;
          bit_cnt_s   = '0;
          state_s     = ST_WAIT_READY;
        end else if (state_r == ST_IDLE) begin
          if (i_cfg_valid && cfg_ready_r) begin
`ifdef CFG_PARITY_EN
            rem_s = {i_cfg_data[FRAME_W-2:0], even_parity(i_cfg_data)};
`else
            rem_s = i_cfg_data[FRAME_W-2:0];
`endif
            sdout_s     = i_cfg_data[FRAME_W-1];
            sclk_s      = 1'b0;
            cfg_ready_s = 1'b0;
            busy_s      = 1'b1;
            half_cnt_s  = '0;
            bit_cnt_s   = '0;
            state_s     = ST_SHIFT;
          end else begin
            cfg_ready_s = 1'b1;
          end
        end else if (state_r == ST_SHIFT) begin
          if (half_cnt_r == HALF_W'(SCLK_HALF - 1)) begin
            half_cnt_s = '0;
            if (!sclk_r) begin
              sclk_s = 1'b1;
            end else begin
              // Falling edge: the only point where data may change.
              sclk_s = 1'b0;
              if (bit_cnt_r == BIT_W'(NBITS - 1)) begin
                sdout_s = 1'b0;
                cnt_s   = '0;
                state_s = ST_GAP;
              end else begin
                bit_cnt_s = bit_cnt_r + BIT_W'(1);
                sdout_s   = rem_r[NBITS-2];
                rem_s     = {rem_r[NBITS-3:0], 1'b0};
              end
            end
          end else begin
            half_cnt_s = half_cnt_r + HALF_W'(1);
          end
        end else begin
          if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
            busy_s      = 1'b0;
            cfg_ready_s = 1'b1;
            cnt_s       = '0;
            state_s     = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
      end
      default: begin
        resetb_all_s = 1'b0;
        cfg_ready_s  = 1'b0;
        sclk_s       = 1'b0;
        sdout_s      = 1'b0;
        busy_s       = 1'b0;
        cnt_s        = '0;
        state_s      = ST_RESET_HOLD;
      end
    endcase
  end

  // State, counter, output and ready-synchroniser registers.
  always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
    if (!i_resetbFPGA) begin
      state_r      <= ST_RESET_HOLD;
      cnt_r        <= '0;
      half_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      rem_r        <= '0;
      ready_meta_r <= 1'b0;
      ready_sync_r <= 1'b0;
      resetb_all_r <= 1'b0;
      cfg_ready_r  <= 1'b0;
      sclk_r       <= 1'b0;
      sdout_r      <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      half_cnt_r   <= half_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      rem_r        <= rem_s;
      ready_meta_r <= i_ready;
      ready_sync_r <= ready_meta_r;
      resetb_all_r <= resetb_all_s;
      cfg_ready_r  <= cfg_ready_s;
      sclk_r       <= sclk_s;
      sdout_r      <= sdout_s;
      busy_r       <= busy_s;
      timeout_r    <= timeout_s;
    end
  end

  assign o_cfg_ready = cfg_ready_r;
  assign o_resetbAll = resetb_all_r;
  assign o_sclk      = sclk_r;
  assign o_sdout     = sdout_r;
  assign o_busy      = busy_r;
  assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_fpga_cfg_sequencer.sv
// Directed self-checking bench for fpga_cfg_sequencer with default parameters.
// Honours CFG_PARITY_EN to expect the extra parity bit.
module tb_fpga_cfg_sequencer;

`ifdef CFG_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       i_mainclk = 1'b0;
  logic       i_resetbFPGA;
  logic       i_ready;
  logic [7:0] i_cfg_data;
  logic       i_cfg_valid;
  logic       o_cfg_ready, o_resetbAll, o_sclk, o_sdout, o_busy, o_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  fpga_cfg_sequencer dut (
    .i_mainclk   (i_mainclk),
    .i_resetbFPGA(i_resetbFPGA),
    .i_ready     (i_ready),
    .i_cfg_data  (i_cfg_data),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .o_resetbAll (o_resetbAll),
    .o_sclk      (o_sclk),
    .o_sdout     (o_sdout),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_mainclk = ~i_mainclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge i_mainclk);
  endtask

  // Frame bits in transmit order, right-aligned in 9 bits.
  function automatic logic [8:0] frame_bits(input logic [7:0] d);
`ifdef CFG_PARITY_EN
    return {d, ^d};
`else
    return {1'b0, d};
`endif
  endfunction

  // Sends one frame from IDLE and checks edges, data, busy length and return to ready.
  task automatic shift_frame(input string tag, input logic [7:0] data, input logic [8:0] exp_bits);
    int rises = 0, first_rise = -1, last_rise = -1, bad_gap = 0, busy_cnt = 0, ready_k = -1;
    logic [8:0] bits = '0;
    logic prev_sclk;
    i_cfg_data  = data;
    i_cfg_valid = 1'b1;
    prev_sclk   = o_sclk;
    for (int k = 1; k <= NB * 8 + 40 && ready_k < 0; k++) begin
      tick();
      if (k == 1) i_cfg_valid = 1'b0;
      busy_cnt += int'(o_busy);
      if (o_sclk && !prev_sclk) begin
        rises++;
        bits = {bits[7:0], o_sdout};
        if (first_rise < 0) first_rise = k;
        else if (k - last_rise != 8) bad_gap++;
        last_rise = k;
      end
      prev_sclk = o_sclk;
      if (o_cfg_ready) ready_k = k;
    end
    chk({tag, "_rises"}, rises, NB);
    chk({tag, "_bits"}, bits, exp_bits);
    chk({tag, "_first_rise"}, first_rise, 5);
    chk({tag, "_rise_spacing_errs"}, bad_gap, 0);
    chk({tag, "_busy_len"}, busy_cnt, NB * 8 + 8);
    chk({tag, "_ready_back"}, ready_k, NB * 8 + 9);
  endtask

  initial begin
    int rb, cr, rises, r_last, r_next, t_rise, m2;
    logic [8:0] b1, b2;
    logic prev, seen_gap, dropped;

    i_resetbFPGA = 1'b0;
    i_ready      = 1'b0;
    i_cfg_data   = 8'h00;
    i_cfg_valid  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {o_cfg_ready, o_resetbAll, o_sclk, o_sdout, o_busy, o_timeout}, 6'b000000);

    // Power-up: ready follows o_resetbAll so the block sees it 10 cycles later.
    i_resetbFPGA = 1'b1;
    rb = -1; cr = -1;
    for (int n = 1; n <= 60 && cr < 0; n++) begin
      tick();
      if (o_resetbAll && rb < 0) rb = n;
      if (rb >= 0 && n == rb + 9) i_ready = 1'b1;
      if (o_cfg_ready) cr = n;
    end
    chk("resetball_rise", rb, 16);
    chk("cfg_ready_delay", cr - rb, 12);
    chk("no_timeout", o_timeout, 1'b0);

    shift_frame("frame_a5", 8'hA5, frame_bits(8'hA5));

    // Abort after the 3rd rising edge.
    i_cfg_data = 8'hFF; i_cfg_valid = 1'b1;
    rises = 0; prev = o_sclk;
    for (int k = 1; k <= 100 && rises < 3; k++) begin
      tick();
      if (k == 1) i_cfg_valid = 1'b0;
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
    end
    chk("abort_pre_rises", rises, 3);
    i_ready = 1'b0;
    repeat (3) tick();
    chk("abort_lines", {o_sclk, o_sdout, o_cfg_ready, o_busy}, 4'b0000);
    rises = 0; prev = o_sclk;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
    end
    chk("abort_quiet", {rises[7:0], o_cfg_ready, o_busy}, 10'd0);
    i_ready = 1'b1;
    repeat (3) tick();
    chk("abort_ready_back", o_cfg_ready, 1'b1);
    shift_frame("post_abort", 8'h5A, frame_bits(8'h5A));

    // Back-to-back with valid held; a valid glitch during SHIFT must not capture.
    i_cfg_data = 8'h3C; i_cfg_valid = 1'b1;
    rises = 0; b1 = '0; b2 = '0; r_last = -1; r_next = -1;
    seen_gap = 1'b0; dropped = 1'b0; prev = o_sclk;
    for (int k = 1; k <= 400 && rises < 2 * NB; k++) begin
      tick();
      if (k == 10) i_cfg_valid = 1'b0;
      if (k == 11) begin i_cfg_valid = 1'b1; i_cfg_data = 8'hC3; end
      if (!o_busy && k > 1) seen_gap = 1'b1;
      if (seen_gap && o_busy && !dropped) begin i_cfg_valid = 1'b0; dropped = 1'b1; end
      if (o_sclk && !prev) begin
        rises++;
        if (rises <= NB) b1 = {b1[7:0], o_sdout};
        else b2 = {b2[7:0], o_sdout};
        if (rises == NB) r_last = k;
        if (rises == NB + 1) r_next = k;
      end
      prev = o_sclk;
    end
    chk("b2b_frame1", b1, frame_bits(8'h3C));
    chk("b2b_frame2", b2, frame_bits(8'hC3));
    chk("b2b_rise_gap", r_next - r_last, 17);
    chk("b2b_min_gap", ((r_next - r_last - 4) >= 9) ? 1 : 0, 1);
    cr = -1;
    for (int k = 1; k <= 120 && cr < 0; k++) begin
      tick();
      if (o_cfg_ready) cr = k;
    end
    chk("b2b_ready_back", (cr > 0) ? 1 : 0, 1);

    // Asynchronous reset mid-frame, then ready held low for the timeout path.
    i_cfg_data = 8'hFF; i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    repeat (20) tick();
    i_ready = 1'b0;
    @(posedge i_mainclk);
    #2 i_resetbFPGA = 1'b0;
    #1 chk("async_reset", {o_cfg_ready, o_resetbAll, o_sclk, o_sdout, o_busy, o_timeout}, 6'b000000);
    tick();
    i_resetbFPGA = 1'b1;
    t_rise = -1;
    for (int n = 1; n <= 1200 && t_rise < 0; n++) begin
      tick();
      if (o_timeout) t_rise = n;
    end
    chk("timeout_cycle", t_rise, 1040);
    chk("timeout_resetb_low", o_resetbAll, 1'b0);
    rb = -1;
    for (int m = 1; m <= 40 && rb < 0; m++) begin
      tick();
      if (o_resetbAll) rb = m;
    end
    chk("retry_hold_len", rb, 16);
    m2 = -1;
    for (int m = 1; m <= 1100 && m2 < 0; m++) begin
      tick();
      if (!o_resetbAll) m2 = m;
    end
    chk("retry_repeat", m2, 1024);
    chk("timeout_sticky", o_timeout, 1'b1);
    i_ready = 1'b1;
    cr = -1;
    for (int k = 1; k <= 80 && cr < 0; k++) begin
      tick();
      if (o_cfg_ready) cr = k;
    end
    chk("recover_ready", (cr > 0) ? 1 : 0, 1);
    chk("timeout_still_sticky", o_timeout, 1'b1);

`ifdef CFG_PARITY_EN
    shift_frame("parity_07", 8'h07, 9'b0_0000_1111);
    shift_frame("parity_03", 8'h03, 9'b0_0000_0110);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
